// File: rtl/rgmii_tx_framer_pkg.sv
`default_nettype none
// =====================================================================
// Package  : rgmii_tx_framer_pkg
// Brief    : Shared state encoding, framing bytes and CRC-32 constants
//            for the RGMII transmit framer.
// Revision : 1.0
// =====================================================================
package rgmii_tx_framer_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SEND  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_PAD   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_FCS   = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_GAP   = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_DROP  = 3'd6;

    localparam logic [7:0]  c_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  c_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] c_CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] c_CRC_INIT      = 32'hFFFFFFFF;

    // Rising DDR edge carries the low nibble of each byte.
    localparam logic c_NIB_LOW_ON_RISE = 1'b1;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// =====================================================================
// Module   : crc32_byte
// Brief    : Combinational next-state of the reflected Ethernet CRC-32
//            register after absorbing one byte (LSB first).
// Revision : 1.0
// =====================================================================
module crc32_byte
    import rgmii_tx_framer_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    localparam logic [31:0] c_POLY_REFL = reflect32(c_CRC_POLY);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ c_POLY_REFL) : (w_crc >> 1);
        end
        o_crc = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/rgmii_tx_framer.sv
`default_nettype none
// =====================================================================
// Module   : rgmii_tx_framer
// Brief    : Byte-wide Ethernet TX framer feeding an external RGMII DDR
//            cell: preamble/SFD, zero padding, CRC-32 FCS and IFG.
// Revision : 1.0
// =====================================================================
module rgmii_tx_framer
    import rgmii_tx_framer_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int IFG_BYTES    = 12,
    parameter int MIN_PAYLOAD  = 60,
    parameter int APPEND_FCS   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        tx_enable,
    output logic        ready,
    output logic        active,
    output logic        dropped,
    output logic [3:0]  tx_nib_rise,
    output logic [3:0]  tx_nib_fall,
    output logic        tx_en_out,
    output logic [15:0] frame_len
);

    localparam logic [4:0]  c_DRAIN_LAST = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0]  c_GAP_LAST   = 5'(IFG_BYTES - 1);
    localparam logic [3:0]  c_PRE_BYTES  = 4'(PREAMBLE_LEN);
    localparam logic [15:0] c_MIN_LEN    = 16'(MIN_PAYLOAD);
    localparam logic [c_STATE_W-1:0] c_ST_AFTER_DATA = (APPEND_FCS != 0) ? c_ST_FCS : c_ST_GAP;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [7:0]  r_sr [PREAMBLE_LEN];
    logic [7:0]  r_hold;
    logic [4:0]  r_cnt;
    logic [3:0]  r_pre_cnt;
    logic [15:0] r_len_cnt;
    logic [15:0] w_len_next;
    logic        w_len_done;
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic        r_rej;
    logic        r_dropped;
    logic        w_in_tail;
    logic        w_drop_start;
    logic [7:0]  w_byte;
    logic        w_en;
    logic        w_shift;
    logic        w_payload;
    logic [7:0]  r_tx_byte;
    logic        r_tx_en;
    logic [15:0] r_frame_len;

    crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_next)
    );

    assign w_fcs      = ~r_crc;
    assign w_len_next = (w_payload && (r_len_cnt != 16'hFFFF)) ? r_len_cnt + 16'd1 : r_len_cnt;
    assign w_len_done = (w_len_next >= c_MIN_LEN);
    assign w_in_tail  = (r_state == c_ST_DRAIN) || (r_state == c_ST_PAD) ||
                        (r_state == c_ST_FCS)   || (r_state == c_ST_GAP);
    assign w_drop_start = tx_enable && !r_rej && w_in_tail;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (tx_enable)  w_state_next = c_ST_SEND;
            c_ST_SEND:  if (!tx_enable) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (r_cnt == c_DRAIN_LAST) w_state_next = w_len_done ? c_ST_AFTER_DATA : c_ST_PAD;
            c_ST_PAD:   if (w_len_done) w_state_next = c_ST_AFTER_DATA;
            c_ST_FCS:   if (r_cnt == 5'd3) w_state_next = c_ST_GAP;
            // A frame still held at the end of the gap was already rejected.
            c_ST_GAP:   if (r_cnt == c_GAP_LAST) w_state_next = tx_enable ? c_ST_DROP : c_ST_IDLE;
            c_ST_DROP:  if (!tx_enable) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte    = 8'h00;
        w_en      = 1'b0;
        w_shift   = 1'b0;
        w_payload = 1'b0;
        case (r_state)
            c_ST_SEND, c_ST_DRAIN: begin
                w_byte    = r_sr[PREAMBLE_LEN-1];
                w_en      = 1'b1;
                w_shift   = 1'b1;
                w_payload = (r_pre_cnt == c_PRE_BYTES);
            end
            c_ST_PAD: begin
                w_en      = 1'b1;
                w_payload = 1'b1;
            end
            c_ST_FCS: begin
                w_en = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_byte = w_fcs[7:0];
                    2'd1:    w_byte = w_fcs[15:8];
                    2'd2:    w_byte = w_fcs[23:16];
                    default: w_byte = w_fcs[31:24];
                endcase
            end
            default: ;
        endcase
    end

    // Delay line: holds the preamble while idle, payload slides in behind it.
    always_ff @(posedge clock) begin
        if (reset || (r_state == c_ST_IDLE)) begin
            for (int i = 0; i < PREAMBLE_LEN; i++) begin
                r_sr[i] <= (i == 0) ? c_SFD_BYTE : c_PREAMBLE_BYTE;
            end
        end else if (w_shift) begin
            r_sr[0] <= r_hold;
            for (int i = 1; i < PREAMBLE_LEN; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold      <= 8'h00;
            r_cnt       <= 5'd0;
            r_pre_cnt   <= 4'd0;
            r_len_cnt   <= 16'd0;
            r_crc       <= c_CRC_INIT;
            r_rej       <= 1'b0;
            r_dropped   <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_en     <= 1'b0;
            r_frame_len <= 16'd0;
        end else begin
            if (tx_enable) begin
                r_hold <= data;
            end
            r_cnt <= (w_state_next != r_state) ? 5'd0 : r_cnt + 5'd1;
            if (r_state == c_ST_IDLE) begin
                r_pre_cnt <= 4'd0;
                r_len_cnt <= 16'd0;
                r_crc     <= c_CRC_INIT;
            end else begin
                if (w_shift && (r_pre_cnt != c_PRE_BYTES)) begin
                    r_pre_cnt <= r_pre_cnt + 4'd1;
                end
                r_len_cnt <= w_len_next;
                if (w_payload) begin
                    r_crc <= w_crc_next;
                end
            end
            r_rej     <= tx_enable ? (r_rej || w_drop_start) : 1'b0;
            r_dropped <= w_drop_start;
            r_tx_byte <= w_byte;
            r_tx_en   <= w_en;
            if ((w_state_next == c_ST_GAP) && (r_state != c_ST_GAP)) begin
                r_frame_len <= w_len_next;
            end
        end
    end

    assign ready       = (r_state == c_ST_IDLE);
    assign active      = (r_state != c_ST_IDLE) || tx_enable;
    assign dropped     = r_dropped;
    assign tx_nib_rise = c_NIB_LOW_ON_RISE ? r_tx_byte[3:0] : r_tx_byte[7:4];
    assign tx_nib_fall = c_NIB_LOW_ON_RISE ? r_tx_byte[7:4] : r_tx_byte[3:0];
    assign tx_en_out   = r_tx_en;
    assign frame_len   = r_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_framer.sv
`default_nettype none
// =====================================================================
// Module   : tb_rgmii_tx_framer
// Brief    : Scoreboard bench for rgmii_tx_framer over three parameter
//            sets (default, no padding, short preamble/short gap).
// Revision : 1.0
// =====================================================================
module tb_rgmii_tx_framer;

    localparam int c_NDUT    = 3;
    localparam int c_TIMEOUT = 3000;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        tx_enable;

    logic        ready   [c_NDUT];
    logic        active  [c_NDUT];
    logic        dropped [c_NDUT];
    logic [3:0]  nib_r   [c_NDUT];
    logic [3:0]  nib_f   [c_NDUT];
    logic        ten     [c_NDUT];
    logic [15:0] flen    [c_NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sel      = 0;
    int byte_cnt = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int drop_cnt  = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        int dut;
        int len;
        int kind;
        int exp_txen;
        int exp_flen;
    } vec_t;

    vec_t vecs [8];

    rgmii_tx_framer #(.PREAMBLE_LEN(8), .IFG_BYTES(12), .MIN_PAYLOAD(60), .APPEND_FCS(1)) u_def (
        .clock(clock), .reset(reset), .data(data), .tx_enable(tx_enable),
        .ready(ready[0]), .active(active[0]), .dropped(dropped[0]),
        .tx_nib_rise(nib_r[0]), .tx_nib_fall(nib_f[0]), .tx_en_out(ten[0]), .frame_len(flen[0])
    );

    rgmii_tx_framer #(.PREAMBLE_LEN(8), .IFG_BYTES(12), .MIN_PAYLOAD(0), .APPEND_FCS(1)) u_nopad (
        .clock(clock), .reset(reset), .data(data), .tx_enable(tx_enable),
        .ready(ready[1]), .active(active[1]), .dropped(dropped[1]),
        .tx_nib_rise(nib_r[1]), .tx_nib_fall(nib_f[1]), .tx_en_out(ten[1]), .frame_len(flen[1])
    );

    rgmii_tx_framer #(.PREAMBLE_LEN(2), .IFG_BYTES(1), .MIN_PAYLOAD(0), .APPEND_FCS(1)) u_small (
        .clock(clock), .reset(reset), .data(data), .tx_enable(tx_enable),
        .ready(ready[2]), .active(active[2]), .dropped(dropped[2]),
        .tx_nib_rise(nib_r[2]), .tx_nib_fall(nib_f[2]), .tx_en_out(ten[2]), .frame_len(flen[2])
    );

    always #4 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int pre_of(input int d);
        return (d == 2) ? 2 : 8;
    endfunction

    function automatic int ifg_of(input int d);
        return (d == 2) ? 1 : 12;
    endfunction

    function automatic int min_of(input int d);
        return (d == 0) ? 60 : 0;
    endfunction

    function automatic logic [7:0] pbyte(input int kind, input int i);
        if (kind == 0) return 8'(8'h31 + i);
        return 8'(i * 37 + kind * 11 + 3);
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else                       c = c >> 1;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor for the DUT currently under test.
    always @(negedge clock) begin
        if (dropped[sel]) drop_cnt++;
        if (ten[sel]) begin
            if (byte_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            byte_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected tx byte: got %0h, required no TX_EN (cycle %0d)",
                         {nib_f[sel], nib_r[sel]}, cyc);
            end else begin
                check("tx byte", 32'({nib_f[sel], nib_r[sel]}), 32'(exp_q.pop_front()));
            end
        end else begin
            check("idle nibbles", 32'({nib_f[sel], nib_r[sel]}), 32'h0);
        end
    end

    task automatic push_model(input int d, input int n, input int kind);
        logic [31:0] crc;
        logic [7:0]  b;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < pre_of(d) - 1; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) begin
            b = pbyte(kind, i);
            exp_q.push_back(b);
            crc = crc_upd(crc, b);
        end
        for (int i = n; i < min_of(d); i++) begin
            exp_q.push_back(8'h00);
            crc = crc_upd(crc, 8'h00);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    endtask

    task automatic start_frame(input int d, output int start);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < c_TIMEOUT; t++) begin
            if (ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("ready before frame", 32'(ok), 32'd1);
        sel       = d;
        byte_cnt  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        drop_cnt  = 0;
        start     = cyc + 1;
    endtask

    task automatic drive_payload(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            data      = pbyte(kind, i);
            tx_enable = 1'b1;
            @(negedge clock);
        end
        tx_enable = 1'b0;
        data      = 8'h00;
    endtask

    task automatic finish_frame(input int d, input int start, input int exp_txen, input int exp_flen);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < c_TIMEOUT; t++) begin
            @(negedge clock);
            if (ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready after frame", 32'(ok), 32'd1);
        check("tx_en byte count", 32'(byte_cnt), 32'(exp_txen));
        check("first byte latency", 32'(first_cyc - start), 32'd1);
        check("tx_en contiguous", 32'(last_cyc - first_cyc + 1), 32'(byte_cnt));
        check("ready after last byte", 32'(cyc - last_cyc), 32'(ifg_of(d)));
        check("frame_len", 32'(flen[d]), 32'(exp_flen));
        check("queue drained", 32'(exp_q.size()), 32'd0);
        check("no drop", 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        int st;
        bit ok;
        logic [7:0] kv [21];

        vecs[0] = '{0, 10, 1, 72, 60};
        vecs[1] = '{0, 70, 2, 82, 70};
        vecs[2] = '{0, 60, 3, 72, 60};
        vecs[3] = '{0, 59, 4, 72, 60};
        vecs[4] = '{1,  1, 5, 13,  1};
        vecs[5] = '{2,  5, 6, 11,  5};
        vecs[6] = '{2,  1, 7,  7,  1};
        vecs[7] = '{1,  3, 8, 15,  3};

        reset     = 1'b1;
        tx_enable = 1'b0;
        data      = 8'h00;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < c_NDUT; d++) begin
            check("reset ready",     32'(ready[d]),   32'd1);
            check("reset active",    32'(active[d]),  32'd0);
            check("reset tx_en",     32'(ten[d]),     32'd0);
            check("reset nibbles",   32'({nib_f[d], nib_r[d]}), 32'h0);
            check("reset frame_len", 32'(flen[d]),    32'd0);
            check("reset dropped",   32'(dropped[d]), 32'd0);
        end

        // Reference vector "123456789": check value CBF43926, LSB first.
        for (int i = 0; i < 7; i++) kv[i] = 8'h55;
        kv[7] = 8'hD5;
        for (int i = 0; i < 9; i++) kv[8 + i] = 8'(8'h31 + i);
        kv[17] = 8'h26;
        kv[18] = 8'h39;
        kv[19] = 8'hF4;
        kv[20] = 8'hCB;
        start_frame(1, st);
        for (int i = 0; i < 21; i++) exp_q.push_back(kv[i]);
        drive_payload(9, 0);
        finish_frame(1, st, 21, 9);

        // Second frame offered 3 cycles into the gap and held past its end.
        start_frame(0, st);
        push_model(0, 20, 9);
        drive_payload(20, 9);
        ok = 1'b0;
        for (int t = 0; t < c_TIMEOUT; t++) begin
            @(negedge clock);
            if ((byte_cnt >= 72) && !ten[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("first frame reaches gap", 32'(ok), 32'd1);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            data      = pbyte(10, i);
            tx_enable = 1'b1;
            @(negedge clock);
        end
        check("ready low while rejected", 32'(ready[0]), 32'd0);
        check("active while rejected",    32'(active[0]), 32'd1);
        tx_enable = 1'b0;
        data      = 8'h00;
        @(negedge clock);
        check("ready after reject release", 32'(ready[0]), 32'd1);
        repeat (20) @(negedge clock);
        check("dropped pulse count", 32'(drop_cnt), 32'd1);
        check("first frame bytes",   32'(byte_cnt), 32'd72);
        check("first frame len",     32'(flen[0]),  32'd60);
        check("reject queue drained", 32'(exp_q.size()), 32'd0);

        // Reset lands on the edge right after payload byte 5 is emitted.
        start_frame(1, st);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(pbyte(11, i));
        for (int j = 0; j < 20; j++) begin
            if (j == pre_of(1) + 7) begin
                reset     = 1'b1;
                tx_enable = 1'b0;
                data      = 8'h00;
                break;
            end
            data      = pbyte(11, j);
            tx_enable = 1'b1;
            @(negedge clock);
        end
        @(negedge clock);
        check("tx_en after reset",    32'(ten[1]),   32'd0);
        check("ready after reset",    32'(ready[1]), 32'd1);
        check("bytes before reset",   32'(byte_cnt), 32'd14);
        check("frame_len after reset", 32'(flen[1]), 32'd0);
        check("reset queue drained",  32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        start_frame(1, st);
        push_model(1, 4, 12);
        drive_payload(4, 12);
        finish_frame(1, st, 16, 4);

        for (int v = 0; v < 8; v++) begin
            start_frame(vecs[v].dut, st);
            push_model(vecs[v].dut, vecs[v].len, vecs[v].kind);
            drive_payload(vecs[v].len, vecs[v].kind);
            finish_frame(vecs[v].dut, st, vecs[v].exp_txen, vecs[v].exp_flen);
        end

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgmii_tx_framer.md
RGMII_TX_FRAMER -- requirements
Module: rgmii_tx_framer

Interface
REQ-001 Parameter PREAMBLE_LEN, default 8, meaning total preamble+SFD bytes; legal 2..15.
REQ-002 Parameter IFG_BYTES, default 12, meaning idle byte times after a frame; legal 1..31.
REQ-003 Parameter MIN_PAYLOAD, default 60, meaning the minimum payload bytes before FCS; shorter frames are zero-padded; 0 disables padding.
REQ-004 Parameter APPEND_FCS, default 1, meaning 1 appends a 4-byte CRC-32 FCS and 0 sends no FCS.
REQ-005 Port clock, input, 1 bit: the single 125 MHz clock; all logic is rising-edge.
REQ-006 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 Port data, input, 8 bits: payload byte, sampled while tx_enable=1.
REQ-008 Port tx_enable, input, 1 bit: high for contiguous payload bytes; the falling edge ends the frame.
REQ-009 Port ready, output, 1 bit: 1 only in IDLE; a frame may start only when ready=1.
REQ-010 Port active, output, 1 bit: 1 from frame acceptance through the end of IFG.
REQ-011 Port dropped, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-012 Port tx_nib_rise, output, 4 bits: current output byte [3:0], for the external DDR cell's rising edge.
REQ-013 Port tx_nib_fall, output, 4 bits: current output byte [7:4], for the falling edge.
REQ-014 Port tx_en_out, output, 1 bit: PHY TX_EN, driven on both edges by the external DDR cell.
REQ-015 Port frame_len, output, 16 bits: payload+pad byte count of the last sent frame; saturates at FFFF.

Function
REQ-016 The output byte stream is PREAMBLE_LEN-1 bytes of 0x55, then 0xD5, then the payload, then 0x00 pad bytes, then the FCS (if enabled), then IFG_BYTES idle bytes.
REQ-017 The payload is delayed by a PREAMBLE_LEN-byte shift register preloaded with the preamble while idle; it shifts only while the frame is being streamed.
REQ-018 Latency: the cycle tx_enable is first sampled high is cycle 0; the first preamble byte appears at cycle 1; payload byte 0 appears at cycle PREAMBLE_LEN+1.
REQ-019 All tx_* outputs are registered; tx_en_out is 1 exactly for output bytes from preamble through the last FCS byte, and 0 during IFG and idle.
REQ-020 Idle output: tx_nib_rise=0, tx_nib_fall=0, tx_en_out=0.
REQ-021 States are IDLE, SEND, DRAIN, PAD, FCS, GAP, DROP.
REQ-022 IDLE to SEND occurs when tx_enable=1.
REQ-023 SEND to DRAIN occurs when tx_enable=0.
REQ-024 DRAIN emits the remaining delay-line bytes; when the delay line is empty, DRAIN goes to PAD if the payload count is below MIN_PAYLOAD, else to FCS if APPEND_FCS=1, else to GAP.
REQ-025 PAD emits 0x00 until the count equals MIN_PAYLOAD, then goes to FCS or GAP.
REQ-026 FCS emits 4 bytes, then goes to GAP.
REQ-027 GAP holds for IFG_BYTES cycles, then goes to IDLE.
REQ-028 The CRC is Ethernet CRC-32: reflected poly 0x04C11DB7, init 0xFFFFFFFF, computed over payload+pad bytes as they exit; the FCS is the complemented CRC, least-significant byte first.
REQ-029 If tx_enable rises while ready=0 (DRAIN/PAD/FCS/GAP), the block pulses dropped, ignores bytes until tx_enable is low, and the in-flight frame and IFG continue unaffected.
REQ-030 If tx_enable is high at the end of GAP, that frame is still rejected (DROP) and is not truncated-and-sent.
REQ-031 From DROP, the block returns to IDLE when tx_enable=0 and the current frame's IFG is complete.
REQ-032 frame_len updates on entry to GAP.
REQ-033 A one-byte payload with MIN_PAYLOAD=0 is legal: PREAMBLE_LEN+1+4 TX_EN bytes.
REQ-034 active = (state != IDLE) or tx_enable.

Reset
REQ-035 On reset, the block enters IDLE, the shift register is loaded with the preamble, the CRC is set to 0xFFFFFFFF, counters are 0, frame_len=0, dropped=0, and tx outputs take idle values on the next cycle.
REQ-036 Reset asserted mid-frame aborts the frame immediately; tx_en_out=0 one cycle later and no FCS is sent.

Structure
REQ-037 The shared package holds the state enumeration, the preamble byte (0x55), the SFD (0xD5), the CRC polynomial/init constants and the nibble order.
REQ-038 One sub-module, crc32_byte, computes the combinational next CRC for 8 bits per cycle.
REQ-039 The DDR output cell and PLL stay outside this block.

Verification
REQ-040 Payload ASCII "123456789" with MIN_PAYLOAD=0 -> output 55x7, D5, 31..39, 26 39 F4 CB; TX_EN high for 21 bytes.
REQ-041 A 10-byte payload with defaults -> 50 pad bytes of 00 follow it, FCS is over 60 bytes, frame_len=60, TX_EN high for 72 bytes.
REQ-042 Back-to-back: tx_enable re-asserted 3 cycles into GAP -> dropped pulses once, the second frame is not sent and the first frame is intact.
REQ-043 PREAMBLE_LEN=2 and IFG_BYTES=1 -> output 55 D5 then the payload at cycle 3; ready returns 1 exactly 1 cycle after the last FCS byte.
REQ-044 Reset during payload byte 5 -> tx_en_out=0 the next cycle, ready=1, and a new frame sends cleanly.
REQ-045 A 70-byte payload -> no padding, frame_len=70, and byte order is preserved.
